// File: rtl/cache_nway_wb.sv
// cache_nway_wb: N-way set-associative write-back, write-allocate data cache with true LRU.
//
// Ports:
//   clk, reset           clock; synchronous active-high reset
//   cpu_read_i/_write_i  load/store request from MEM stage (write wins if both high)
//   cpu_addr_i           byte address, bits [1:0] ignored
//   cpu_wdata_i          store data
//   cpu_rdata_o          load data of the matching way, 0 without a hit
//   hit_o, stall_o       combinational hit / pipeline freeze
//   mem_req_o, mem_we_o  level request to line memory; we=1 write-back, we=0 refill
//   mem_addr_o           line-aligned address
//   mem_wdata_o          victim line during write-back
//   mem_rdata_i          refill line, valid with mem_ready_i
//   mem_ready_i          one-cycle completion pulse
//
// Optional: define CACHE_PERF_CNT_EN to add saturating perf_hits_o, perf_misses_o and
// perf_writebacks_o counters.
module cache_nway_wb #(
   parameter int unsigned WAYS       = 2,
   parameter int unsigned SETS       = 1024,
   parameter int unsigned LINE_WORDS = 4
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       cpu_read_i,
   input  logic                       cpu_write_i,
   input  logic [31:0]                cpu_addr_i,
   input  logic [31:0]                cpu_wdata_i,
   output logic [31:0]                cpu_rdata_o,
   output logic                       hit_o,
   output logic                       stall_o,
   output logic                       mem_req_o,
   output logic                       mem_we_o,
   output logic [31:0]                mem_addr_o,
   output logic [32*LINE_WORDS-1:0]   mem_wdata_o,
   input  logic [32*LINE_WORDS-1:0]   mem_rdata_i,
   input  logic                       mem_ready_i
`ifdef CACHE_PERF_CNT_EN
   ,
   output logic [31:0]                perf_hits_o,
   output logic [31:0]                perf_misses_o,
   output logic [31:0]                perf_writebacks_o
`endif
);

   localparam int unsigned WOW = $clog2(LINE_WORDS);
   localparam int unsigned OFF = WOW + 2;
   localparam int unsigned IDX = $clog2(SETS);
   localparam int unsigned TAG = 32 - IDX - OFF;
   localparam int unsigned LW  = 32 * LINE_WORDS;
   localparam int unsigned AW  = (WAYS > 1) ? $clog2(WAYS) : 1;

   typedef enum logic [1:0] {StIdle, StWb, StRefill, StDone} state_e;

   state_e state_q, state_d;

   logic [LW-1:0]  data_q  [WAYS][SETS];
   logic [TAG-1:0] tags_q  [WAYS][SETS];
   logic           valid_q [WAYS][SETS];
   logic           dirty_q [WAYS][SETS];
   logic [AW-1:0]  age_q   [WAYS][SETS];

   logic [AW-1:0]  victim_q, victim_d;
   logic [IDX-1:0] ridx_q, ridx_d;
   logic [TAG-1:0] rtag_q, rtag_d;

   logic           req;
   logic [TAG-1:0] cpu_tag;
   logic [IDX-1:0] cpu_idx;
   logic [WOW-1:0] cpu_word;
   logic           hit_any;
   logic [AW-1:0]  hit_way;
   logic [LW-1:0]  hit_line;
   logic [AW-1:0]  victim;
   logic           victim_found;
   logic           refill_done;
   logic           lru_en;
   logic [AW-1:0]  lru_way;
   logic [IDX-1:0] lru_idx;
   logic           unused_addr_bits;

   assign req              = cpu_read_i | cpu_write_i;
   assign cpu_tag          = cpu_addr_i[31:IDX+OFF];
   assign cpu_idx          = cpu_addr_i[IDX+OFF-1:OFF];
   assign cpu_word         = cpu_addr_i[OFF-1:2];
   assign unused_addr_bits = ^cpu_addr_i[1:0];
   assign refill_done      = (state_q == StRefill) & mem_ready_i;

   always_comb begin
      hit_any = 1'b0;
      hit_way = '0;
      for (int w = 0; w < WAYS; w++) begin
         if (valid_q[w][cpu_idx] && tags_q[w][cpu_idx] == cpu_tag) begin
            hit_any = 1'b1;
            hit_way = AW'(w);
         end
      end
   end

   assign hit_line    = data_q[hit_way][cpu_idx];
   assign hit_o       = req & (state_q == StIdle) & hit_any;
   assign stall_o     = req & ~hit_o;
   assign cpu_rdata_o = hit_o ? hit_line[{cpu_word, 5'd0} +: 32] : 32'd0;

   // Lowest invalid way first, otherwise the way whose age marks it LRU.
   always_comb begin
      victim       = '0;
      victim_found = 1'b0;
      for (int w = 0; w < WAYS; w++) begin
         if (!victim_found && !valid_q[w][cpu_idx]) begin
            victim       = AW'(w);
            victim_found = 1'b1;
         end
      end
      if (!victim_found) begin
         for (int w = 0; w < WAYS; w++) begin
            if (age_q[w][cpu_idx] == AW'(WAYS - 1)) victim = AW'(w);
         end
      end
   end

   always_comb begin
      state_d     = state_q;
      victim_d    = victim_q;
      ridx_d      = ridx_q;
      rtag_d      = rtag_q;
      mem_req_o   = 1'b0;
      mem_we_o    = 1'b0;
      mem_addr_o  = 32'd0;
      mem_wdata_o = '0;
      unique case (state_q)
         StIdle: begin
            if (req && !hit_any) begin
               victim_d = victim;
               ridx_d   = cpu_idx;
               rtag_d   = cpu_tag;
               state_d  = (valid_q[victim][cpu_idx] && dirty_q[victim][cpu_idx]) ? StWb
                                                                                 : StRefill;
            end
         end
         StWb: begin
            mem_req_o   = 1'b1;
            mem_we_o    = 1'b1;
            mem_addr_o  = {tags_q[victim_q][ridx_q], ridx_q, {OFF{1'b0}}};
            mem_wdata_o = data_q[victim_q][ridx_q];
            if (mem_ready_i) state_d = StRefill;
         end
         StRefill: begin
            mem_req_o  = 1'b1;
            mem_addr_o = {rtag_q, ridx_q, {OFF{1'b0}}};
            if (mem_ready_i) state_d = StDone;
         end
         StDone: state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   // A hit and a refill completion never coincide: hits need StIdle.
   always_comb begin
      lru_en  = 1'b0;
      lru_way = hit_way;
      lru_idx = cpu_idx;
      if (hit_o) begin
         lru_en = 1'b1;
      end else if (refill_done) begin
         lru_en  = 1'b1;
         lru_way = victim_q;
         lru_idx = ridx_q;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= StIdle;
         victim_q <= '0;
         ridx_q   <= '0;
         rtag_q   <= '0;
      end else begin
         state_q  <= state_d;
         victim_q <= victim_d;
         ridx_q   <= ridx_d;
         rtag_q   <= rtag_d;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int w = 0; w < WAYS; w++) begin
            for (int s = 0; s < SETS; s++) begin
               valid_q[w][s] <= 1'b0;
               dirty_q[w][s] <= 1'b0;
               age_q[w][s]   <= AW'(w);
            end
         end
      end else begin
         if (hit_o && cpu_write_i) dirty_q[hit_way][cpu_idx] <= 1'b1;
         if (state_q == StWb && mem_ready_i) valid_q[victim_q][ridx_q] <= 1'b0;
         if (refill_done) begin
            valid_q[victim_q][ridx_q] <= 1'b1;
            dirty_q[victim_q][ridx_q] <= 1'b0;
         end
         if (lru_en) begin
            for (int w = 0; w < WAYS; w++) begin
               if (AW'(w) == lru_way) begin
                  age_q[w][lru_idx] <= '0;
               end else if (age_q[w][lru_idx] < age_q[lru_way][lru_idx]) begin
                  age_q[w][lru_idx] <= age_q[w][lru_idx] + 1'b1;
               end
            end
         end
      end
   end

   // Line storage carries no reset; validity alone decides what is live.
   always_ff @(posedge clk) begin
      if (!reset) begin
         if (hit_o && cpu_write_i) data_q[hit_way][cpu_idx][{cpu_word, 5'd0} +: 32] <= cpu_wdata_i;
         if (refill_done) begin
            data_q[victim_q][ridx_q] <= mem_rdata_i;
            tags_q[victim_q][ridx_q] <= rtag_q;
         end
      end
   end

`ifdef CACHE_PERF_CNT_EN
   logic [31:0] perf_hits_q, perf_misses_q, perf_wbs_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         perf_hits_q   <= '0;
         perf_misses_q <= '0;
         perf_wbs_q    <= '0;
      end else begin
         if (hit_o && perf_hits_q != '1) perf_hits_q <= perf_hits_q + 32'd1;
         if (state_q == StIdle && req && !hit_any && perf_misses_q != '1)
            perf_misses_q <= perf_misses_q + 32'd1;
         if (state_q == StWb && mem_ready_i && perf_wbs_q != '1) perf_wbs_q <= perf_wbs_q + 32'd1;
      end
   end

   assign perf_hits_o       = perf_hits_q;
   assign perf_misses_o     = perf_misses_q;
   assign perf_writebacks_o = perf_wbs_q;
`endif

endmodule

// File: tb/tb_cache_nway_wb.sv
// tb_cache_nway_wb: drives directed and random CPU accesses into cache_nway_wb while acting as
// the line memory, and checks every cycle against a behavioural cache model (per-set way
// contents plus last-use timestamps for LRU) and a sparse memory image.
module tb_cache_nway_wb;

   localparam int unsigned WAYS       = 2;
   localparam int unsigned SETS       = 1024;
   localparam int unsigned LINE_WORDS = 4;
   localparam int unsigned OFF        = $clog2(LINE_WORDS) + 2;
   localparam int unsigned IDX        = $clog2(SETS);
   localparam int unsigned LW         = 32 * LINE_WORDS;

   logic          clk, reset;
   logic          cpu_read, cpu_write;
   logic [31:0]   cpu_addr, cpu_wdata, cpu_rdata;
   logic          hit, stall, mem_req, mem_we, mem_ready;
   logic [31:0]   mem_addr;
   logic [LW-1:0] mem_wdata, mem_rdata;

   int total = 0;
   int bad   = 0;

   cache_nway_wb #(.WAYS(WAYS), .SETS(SETS), .LINE_WORDS(LINE_WORDS)) dut (
      .clk         (clk),
      .reset       (reset),
      .cpu_read_i  (cpu_read),
      .cpu_write_i (cpu_write),
      .cpu_addr_i  (cpu_addr),
      .cpu_wdata_i (cpu_wdata),
      .cpu_rdata_o (cpu_rdata),
      .hit_o       (hit),
      .stall_o     (stall),
      .mem_req_o   (mem_req),
      .mem_we_o    (mem_we),
      .mem_addr_o  (mem_addr),
      .mem_wdata_o (mem_wdata),
      .mem_rdata_i (mem_rdata),
      .mem_ready_i (mem_ready)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Behavioural model
   bit            m_valid [WAYS][SETS];
   bit            m_dirty [WAYS][SETS];
   int unsigned   m_tag   [WAYS][SETS];
   logic [LW-1:0] m_line  [WAYS][SETS];
   longint        m_used  [WAYS][SETS];
   longint        stamp;
   logic [LW-1:0] mem [int unsigned];

   function automatic int unsigned a_tag(input logic [31:0] a);
      return a >> (IDX + OFF);
   endfunction
   function automatic int unsigned a_idx(input logic [31:0] a);
      return (a >> OFF) & (SETS - 1);
   endfunction
   function automatic int unsigned a_word(input logic [31:0] a);
      return (a >> 2) & (LINE_WORDS - 1);
   endfunction
   function automatic logic [31:0] line_addr(input int unsigned t, input int unsigned s);
      return (t << (IDX + OFF)) | (s << OFF);
   endfunction

   function automatic logic [LW-1:0] get_line(input int unsigned la);
      logic [LW-1:0] ln;
      if (!mem.exists(la)) begin
         for (int i = 0; i < LINE_WORDS; i++) ln[i*32 +: 32] = $urandom;
         mem[la] = ln;
      end
      return mem[la];
   endfunction

   task automatic model_reset();
      stamp = 0;
      for (int w = 0; w < WAYS; w++) begin
         for (int s = 0; s < SETS; s++) begin
            m_valid[w][s] = 1'b0;
            m_dirty[w][s] = 1'b0;
            m_used[w][s]  = -w;  // way 0 most recent, last way least recent
         end
      end
   endtask

   task automatic touch(input int w, input int unsigned s);
      stamp++;
      m_used[w][s] = stamp;
   endtask

   function automatic int find_way(input int unsigned s, input int unsigned t);
      for (int w = 0; w < WAYS; w++) if (m_valid[w][s] && m_tag[w][s] == t) return w;
      return -1;
   endfunction

   function automatic int pick_victim(input int unsigned s);
      int v;
      for (int w = 0; w < WAYS; w++) if (!m_valid[w][s]) return w;
      v = 0;
      for (int w = 1; w < WAYS; w++) if (m_used[w][s] < m_used[v][s]) v = w;
      return v;
   endfunction

   task automatic chk(input string nm, input bit eh, input bit es, input logic [31:0] er,
                      input bit ereq, input bit ewe, input logic [31:0] ea,
                      input logic [LW-1:0] ew, input bit cw);
      total++;
      if (hit !== eh || stall !== es || cpu_rdata !== er || mem_req !== ereq ||
          mem_we !== ewe || mem_addr !== ea || (cw && mem_wdata !== ew)) begin
         bad++;
         $display("FAIL %s t=%0t: got hit=%0b stall=%0b rdata=%h req=%0b we=%0b addr=%h wdata=%h; want hit=%0b stall=%0b rdata=%h req=%0b we=%0b addr=%h wdata=%h",
                  nm, $time, hit, stall, cpu_rdata, mem_req, mem_we, mem_addr, mem_wdata,
                  eh, es, er, ereq, ewe, ea, ew);
      end
   endtask

   task automatic lit(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", nm, act, exp);
      end
   endtask

   task automatic idle_cycle(input bit rdy);
      @(posedge clk); #1;
      cpu_read  = 1'b0;
      cpu_write = 1'b0;
      mem_ready = rdy;
      @(negedge clk);
      chk("idle", 0, 0, 32'd0, 0, 0, 32'd0, '0, 1);
   endtask

   task automatic do_reset();
      @(posedge clk); #1;
      reset = 1'b1; cpu_read = 1'b0; cpu_write = 1'b0; mem_ready = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      reset = 1'b0;
      model_reset();
      @(negedge clk);
      chk("reset_state", 0, 0, 32'd0, 0, 0, 32'd0, '0, 1);
   endtask

   // Final cycle of an access that hits in the model; updates the model for writes.
   task automatic hit_cycle(input string nm, input bit wr, input int w, input int unsigned s,
                            input int unsigned wi, input logic [31:0] wd,
                            output logic [31:0] rd);
      rd = m_line[w][s][wi*32 +: 32];
      @(negedge clk);
      chk(nm, 1, 0, rd, 0, 0, 32'd0, '0, 1);
      if (wr) begin
         m_line[w][s][wi*32 +: 32] = wd;
         m_dirty[w][s] = 1'b1;
      end
      touch(w, s);
   endtask

   task automatic do_access(input bit wr, input logic [31:0] a, input logic [31:0] wd,
                            input int dwb, input int drf,
                            output bit was_miss, output bit was_wb, output logic [31:0] wb_addr,
                            output logic [LW-1:0] wb_data, output logic [31:0] rf_addr,
                            output logic [31:0] rd);
      int unsigned s, t, wi;
      int          w, v;
      s = a_idx(a); t = a_tag(a); wi = a_word(a);
      was_miss = 0; was_wb = 0; wb_addr = 0; wb_data = '0; rf_addr = 0;
      @(posedge clk); #1;
      cpu_read = !wr; cpu_write = wr; cpu_addr = a; cpu_wdata = wd; mem_ready = 1'b0;
      w = find_way(s, t);
      if (w >= 0) begin
         hit_cycle("hit", wr, w, s, wi, wd, rd);
         return;
      end
      was_miss = 1;
      v = pick_victim(s);
      @(negedge clk);
      chk("miss_idle", 0, 1, 32'd0, 0, 0, 32'd0, '0, 1);
      if (m_valid[v][s] && m_dirty[v][s]) begin
         was_wb  = 1;
         wb_addr = line_addr(m_tag[v][s], s);
         wb_data = m_line[v][s];
         for (int c = 0; c <= dwb; c++) begin
            @(posedge clk); #1;
            mem_ready = (c == dwb);
            @(negedge clk);
            chk("wb", 0, 1, 32'd0, 1, 1, wb_addr, wb_data, 1);
         end
         mem[wb_addr] = wb_data;
         m_valid[v][s] = 1'b0;
      end
      rf_addr = line_addr(t, s);
      for (int c = 0; c <= drf; c++) begin
         @(posedge clk); #1;
         mem_ready = (c == drf);
         mem_rdata = get_line(rf_addr);
         @(negedge clk);
         chk("refill", 0, 1, 32'd0, 1, 0, rf_addr, '0, 0);
      end
      m_line[v][s]  = mem[rf_addr];
      m_tag[v][s]   = t;
      m_valid[v][s] = 1'b1;
      m_dirty[v][s] = 1'b0;
      touch(v, s);
      @(posedge clk); #1;
      mem_ready = 1'($urandom_range(0, 1));  // ignored in DONE
      @(negedge clk);
      chk("done", 0, 1, 32'd0, 0, 0, 32'd0, '0, 1);
      @(posedge clk); #1;
      mem_ready = 1'b0;
      hit_cycle("post_fill", wr, v, s, wi, wd, rd);
   endtask

   bit            miss, wb;
   logic [31:0]   wba, rfa, rd;
   logic [LW-1:0] wbd;
   logic [31:0]   addr;
   int unsigned   tsel, isel;

   initial begin
      reset = 1'b1; cpu_read = 1'b0; cpu_write = 1'b0; cpu_addr = '0; cpu_wdata = '0;
      mem_ready = 1'b0; mem_rdata = '0;
      model_reset();
      mem[32'h1000] = {32'hDDDD_0003, 32'hCCCC_0002, 32'hBBBB_0001, 32'hAAAA_0000};
      do_reset();

      // Cold read, then a hit in the same line
      do_access(0, 32'h1000, 0, 0, 3, miss, wb, wba, wbd, rfa, rd);
      lit("cold_miss", 32'(miss), 1);
      lit("cold_refill_addr", rfa, 32'h1000);
      lit("cold_rdata", rd, 32'hAAAA_0000);
      do_access(0, 32'h1008, 0, 0, 0, miss, wb, wba, wbd, rfa, rd);
      lit("warm_hit", 32'(miss), 0);
      lit("warm_rdata", rd, 32'hCCCC_0002);

      // Write hit then read back
      do_access(1, 32'h1004, 32'hDEAD_BEEF, 0, 0, miss, wb, wba, wbd, rfa, rd);
      lit("wr_hit", 32'(miss), 0);
      do_access(0, 32'h1004, 0, 0, 0, miss, wb, wba, wbd, rfa, rd);
      lit("wr_readback", rd, 32'hDEAD_BEEF);

      // Fill both ways, touch 0x1000, clean eviction of the 0x5000 way
      do_access(0, 32'h5000, 0, 0, 1, miss, wb, wba, wbd, rfa, rd);
      do_access(0, 32'h1000, 0, 0, 0, miss, wb, wba, wbd, rfa, rd);
      do_access(0, 32'h9000, 0, 0, 2, miss, wb, wba, wbd, rfa, rd);
      lit("clean_evict_nowb", 32'(wb), 0);
      lit("clean_evict_refill", rfa, 32'h9000);
      do_access(0, 32'h1000, 0, 0, 0, miss, wb, wba, wbd, rfa, rd);
      lit("survivor_hit", 32'(miss), 0);

      // Dirty 0x5000, make it LRU, then force its write-back
      do_access(1, 32'h5000, 32'h11, 0, 1, miss, wb, wba, wbd, rfa, rd);
      do_access(0, 32'h1000, 0, 0, 0, miss, wb, wba, wbd, rfa, rd);
      do_access(0, 32'h9000, 0, 20, 2, miss, wb, wba, wbd, rfa, rd);
      lit("dirty_wb", 32'(wb), 1);
      lit("dirty_wb_addr", wba, 32'h5000);
      lit("dirty_wb_word0", wbd[31:0], 32'h11);
      lit("dirty_refill_addr", rfa, 32'h9000);
      idle_cycle(1'b1);

      // Reset in the middle of a refill
      do_reset();
      @(posedge clk); #1;
      cpu_read = 1'b1; cpu_addr = 32'h1000; mem_ready = 1'b0;
      @(negedge clk);
      chk("rst_miss", 0, 1, 32'd0, 0, 0, 32'd0, '0, 1);
      for (int c = 0; c < 3; c++) begin
         @(posedge clk); #1;
         @(negedge clk);
         chk("rst_refill_wait", 0, 1, 32'd0, 1, 0, 32'h1000, '0, 0);
      end
      @(posedge clk); #1;
      reset = 1'b1; cpu_read = 1'b0;
      @(posedge clk); #1;
      reset = 1'b0; mem_ready = 1'b1;
      model_reset();
      @(negedge clk);
      chk("rst_after", 0, 0, 32'd0, 0, 0, 32'd0, '0, 1);
      idle_cycle(1'b1);
      do_access(0, 32'h1000, 0, 0, 1, miss, wb, wba, wbd, rfa, rd);
      lit("rst_remiss", 32'(miss), 1);
      lit("rst_remiss_rdata", rd, 32'hAAAA_0000);

      // Random traffic over a few contended sets
      for (int n = 0; n < 300; n++) begin
         tsel = $urandom_range(0, 3);
         isel = $urandom_range(0, 2);
         addr = line_addr((tsel == 3) ? 5 : tsel,
                          (isel == 0) ? 32'h100 : (isel == 1) ? 32'h101 : 32'h3FF);
         addr = addr | ($urandom_range(0, LINE_WORDS - 1) << 2);
         do_access(1'($urandom_range(0, 1)), addr, $urandom, $urandom_range(0, 4),
                   $urandom_range(0, 4), miss, wb, wba, wbd, rfa, rd);
         if ($urandom_range(0, 3) == 0) idle_cycle(1'($urandom_range(0, 1)));
      end
      idle_cycle(1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
